// File: rtl/apb_slave_bank.sv
// APB completer bank: NUM_SLAVES register files with programmable wait states.
// Define APB_SLVERR_EN to enable address/select error detection and pslverr.
module apb_slave_bank #(
    parameter int NUM_SLAVES  = 3,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int REG_DEPTH   = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic [NUM_SLAVES-1:0] pselx,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int IDX_W = $clog2(REG_DEPTH);
    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  wr_q, err_q, err_d;
    logic [DATA_WIDTH-1:0] rbuf_q, rdat_d;
    logic [DATA_WIDTH-1:0] mem [NUM_SLAVES][REG_DEPTH];
    logic                  any_sel, setup, done, load_rd;

    assign any_sel = |pselx;
    assign setup   = (state == IDLE) && any_sel && !penable;
    assign done    = (state == ACCESS) && (cnt == 4'd0) && penable && any_sel;
    assign idx_d   = paddr[2 +: IDX_W];

    // Lowest set select bit wins; only matters when errors are not reported.
    always_comb begin
        sel_d = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--)
            if (pselx[i]) sel_d = SEL_W'(i);
    end

`ifdef APB_SLVERR_EN
    logic onehot;
    assign onehot  = (pselx & (pselx - NUM_SLAVES'(1))) == '0;
    assign err_d   = !onehot || (paddr[1:0] != 2'b00) || ((paddr >> (2 + IDX_W)) != '0);
    assign pslverr = pready && err_q;
`else
    logic unused_addr;
    assign unused_addr = ^{paddr[1:0], paddr[ADDR_WIDTH-1:2+IDX_W]};
    assign err_d       = 1'b0;
    assign pslverr     = 1'b0;
`endif

    assign rdat_d = err_d ? '0 : mem[sel_d][idx_d];
    assign pready = (state == ACCESS) && (cnt == 4'd0);

    // prdata moves only when entering the cycle in which a read completes.
    assign load_rd = (setup && !pwrite && (WAIT_STATES == 0)) ||
                     ((state == ACCESS) && (cnt == 4'd1) && penable && any_sel && !wr_q);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (setup) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = 4'(WAIT_STATES);
                end
            end
            ACCESS: begin
                if (!(penable && any_sel)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            sel_q  <= '0;
            idx_q  <= '0;
            wr_q   <= 1'b0;
            err_q  <= 1'b0;
            rbuf_q <= '0;
            prdata <= '0;
        end else begin
            if (setup) begin
                sel_q  <= sel_d;
                idx_q  <= idx_d;
                wr_q   <= pwrite;
                err_q  <= err_d;
                rbuf_q <= rdat_d;
            end
            if (load_rd)
                prdata <= (state == IDLE) ? rdat_d : rbuf_q;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int s = 0; s < NUM_SLAVES; s++)
                for (int w = 0; w < REG_DEPTH; w++)
                    mem[s][w] <= '0;
        end else if (done && wr_q && !err_q) begin
            mem[sel_q][idx_q] <= pwdata;
        end
    end

endmodule

// File: tb/tb_apb_slave_bank.sv
// Directed bench for apb_slave_bank: three instances with 0, 2 and 3 wait states
// share the bus; each transfer selects exactly one instance via its own pselx.
module tb_apb_slave_bank;

`ifdef APB_SLVERR_EN
    localparam bit SLVERR = 1'b1;
`else
    localparam bit SLVERR = 1'b0;
`endif

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic [2:0]  sel [3];
    logic        penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [31:0] rd [3];
    logic        rdy [3], serr [3];
    int          checks = 0, errors = 0, cyc = 0;

    always #5 hclk = ~hclk;
    always @(posedge hclk) cyc++;

    initial begin
        for (int i = 0; i < 3; i++) sel[i] = '0;
    end

    apb_slave_bank #(.WAIT_STATES(0)) u_w0 (.hclk(hclk), .hresetn(hresetn), .pselx(sel[0]),
        .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(rd[0]), .pready(rdy[0]), .pslverr(serr[0]));
    apb_slave_bank #(.WAIT_STATES(2)) u_w2 (.hclk(hclk), .hresetn(hresetn), .pselx(sel[1]),
        .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(rd[1]), .pready(rdy[1]), .pslverr(serr[1]));
    apb_slave_bank #(.WAIT_STATES(3)) u_w3 (.hclk(hclk), .hresetn(hresetn), .pselx(sel[2]),
        .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(rd[2]), .pready(rdy[2]), .pslverr(serr[2]));

    // Drives setup then access; returns data/err sampled in the pready cycle.
    // Leaves the bus idle so the next call starts its setup in the following cycle.
    task automatic xfer(input int d, input logic [2:0] s, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rdv, output logic erv,
                        output int waits);
        sel[d] = s; pwrite = wr; paddr = a; pwdata = wd; penable = 1'b0;
        @(posedge hclk); #1 penable = 1'b1;
        waits = 0;
        while (!rdy[d] && waits < 20) begin
            @(posedge hclk); #1;
            waits++;
        end
        checks++;
        if (!rdy[d]) begin
            errors++;
            $display("FAIL xfer_timeout dut=%0d addr=%h pready=%b required=1", d, a, rdy[d]);
        end
        rdv = rd[d]; erv = serr[d];
        @(posedge hclk); #1 sel[d] = '0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r; logic e; int w;
        #1;
        checks++; if (rdy[0] !== 1'b0 || serr[0] !== 1'b0 || rd[0] !== 32'h0) begin
            errors++; $display("FAIL reset_init rdy=%b err=%b rd=%h required 0/0/0", rdy[0], serr[0], rd[0]); end
        @(posedge hclk); #1 hresetn = 1'b1;
        xfer(2, 3'b010, 1'b1, 32'h14, 32'h12345678, r, e, w);
        checks++; if (w !== 3) begin errors++; $display("FAIL w3_write_waits got=%0d exp=3", w); end
        xfer(2, 3'b010, 1'b0, 32'h14, 32'h0, r, e, w);
        checks++; if (r !== 32'h12345678) begin errors++; $display("FAIL w3_read got=%h exp=12345678", r); end
        // start a read and reset it while in the wait states
        sel[2] = 3'b010; pwrite = 1'b0; paddr = 32'h14; penable = 1'b0;
        @(posedge hclk); #1 penable = 1'b1;
        @(posedge hclk); #1;
        checks++; if (rdy[2] !== 1'b0 || rd[2] !== 32'h12345678) begin
            errors++; $display("FAIL mid_access rdy=%b rd=%h exp 0/12345678", rdy[2], rd[2]); end
        hresetn = 1'b0; #1;
        checks++; if (rdy[2] !== 1'b0 || serr[2] !== 1'b0 || rd[2] !== 32'h0) begin
            errors++; $display("FAIL reset_mid rdy=%b err=%b rd=%h required 0/0/0", rdy[2], serr[2], rd[2]); end
        sel[2] = '0; penable = 1'b0;
        @(posedge hclk); #1 hresetn = 1'b1;
        xfer(2, 3'b010, 1'b0, 32'h14, 32'h0, r, e, w);
        checks++; if (r !== 32'h0 || w !== 3) begin
            errors++; $display("FAIL reset_mem rd=%h waits=%0d exp 0/3", r, w); end
    endtask

    task automatic test_write_read();
        logic [31:0] r; logic e; int w;
        xfer(0, 3'b010, 1'b1, 32'h14, 32'hDEADBEEF, r, e, w);
        checks++; if (w !== 0 || e !== 1'b0) begin errors++; $display("FAIL w0_write waits=%0d err=%b exp 0/0", w, e); end
        xfer(0, 3'b010, 1'b0, 32'h14, 32'h0, r, e, w);
        checks++; if (r !== 32'hDEADBEEF || w !== 0) begin
            errors++; $display("FAIL w0_read rd=%h waits=%0d exp deadbeef/0", r, w); end
    endtask

    task automatic test_isolation();
        logic [31:0] r; logic e; int w;
        xfer(0, 3'b001, 1'b1, 32'h8, 32'h11111111, r, e, w);
        xfer(0, 3'b100, 1'b1, 32'h8, 32'h22222222, r, e, w);
        xfer(0, 3'b001, 1'b0, 32'h8, 32'h0, r, e, w);
        checks++; if (r !== 32'h11111111) begin errors++; $display("FAIL iso_s0 got=%h exp=11111111", r); end
        xfer(0, 3'b100, 1'b0, 32'h8, 32'h0, r, e, w);
        checks++; if (r !== 32'h22222222) begin errors++; $display("FAIL iso_s2 got=%h exp=22222222", r); end
        xfer(0, 3'b010, 1'b0, 32'h8, 32'h0, r, e, w);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL iso_s1 got=%h exp=0", r); end
    endtask

    task automatic test_wait_states();
        logic [31:0] r; logic e; int w;
        xfer(1, 3'b001, 1'b1, 32'hC, 32'h5A5A5A5A, r, e, w);
        checks++; if (w !== 2) begin errors++; $display("FAIL w2_write_waits got=%0d exp=2", w); end
        xfer(1, 3'b001, 1'b0, 32'hC, 32'h0, r, e, w);
        checks++; if (w !== 2 || r !== 32'h5A5A5A5A) begin
            errors++; $display("FAIL w2_read waits=%0d rd=%h exp 2/5a5a5a5a", w, r); end
        // write aborted by dropping penable before pready
        sel[1] = 3'b001; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'hFFFFFFFF; penable = 1'b0;
        @(posedge hclk); #1 penable = 1'b1;
        checks++; if (rdy[1] !== 1'b0) begin errors++; $display("FAIL abort_a1 rdy=%b exp=0", rdy[1]); end
        @(posedge hclk); #1;
        checks++; if (rdy[1] !== 1'b0) begin errors++; $display("FAIL abort_a2 rdy=%b exp=0", rdy[1]); end
        penable = 1'b0; sel[1] = '0;
        @(posedge hclk); #1;
        checks++; if (rdy[1] !== 1'b0) begin errors++; $display("FAIL abort_idle rdy=%b exp=0", rdy[1]); end
        xfer(1, 3'b001, 1'b0, 32'hC, 32'h0, r, e, w);
        checks++; if (r !== 32'h5A5A5A5A) begin errors++; $display("FAIL abort_mem got=%h exp=5a5a5a5a", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic e; int w, c0;
        c0 = cyc;
        xfer(0, 3'b100, 1'b1, 32'h3C, 32'hCAFEF00D, r, e, w);
        xfer(0, 3'b100, 1'b0, 32'h3C, 32'h0, r, e, w);
        checks++; if (cyc - c0 !== 4 || r !== 32'hCAFEF00D) begin
            errors++; $display("FAIL b2b cycles=%0d rd=%h exp 4/cafef00d", cyc - c0, r); end
        // a write completion leaves prdata alone
        xfer(0, 3'b100, 1'b1, 32'h38, 32'h00000777, r, e, w);
        checks++; if (rd[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL prdata_hold got=%h exp=cafef00d", rd[0]); end
    endtask

    task automatic test_errors();
        logic [31:0] r, s0; logic e; int w;
        s0 = SLVERR ? 32'h01010101 : 32'h000000AA;
        xfer(0, 3'b001, 1'b1, 32'h0, 32'h01010101, r, e, w);
        xfer(0, 3'b011, 1'b1, 32'h0, 32'h000000AA, r, e, w);
        checks++; if (e !== SLVERR) begin errors++; $display("FAIL err_sel got=%b exp=%b", e, SLVERR); end
        xfer(0, 3'b010, 1'b0, 32'h0, 32'h0, r, e, w);
        checks++; if (r !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL err_s1 rd=%h err=%b exp 0/0", r, e); end
        xfer(0, 3'b001, 1'b0, 32'h0, 32'h0, r, e, w);
        checks++; if (r !== s0 || e !== 1'b0) begin errors++; $display("FAIL err_s0 rd=%h err=%b exp %h/0", r, e, s0); end
        xfer(0, 3'b001, 1'b0, 32'h42, 32'h0, r, e, w);
        checks++; if (e !== SLVERR || r !== (SLVERR ? 32'h0 : s0)) begin
            errors++; $display("FAIL err_misalign rd=%h err=%b exp %h/%b", r, e, SLVERR ? 32'h0 : s0, SLVERR); end
        xfer(0, 3'b001, 1'b0, 32'h0, 32'h0, r, e, w);
        xfer(0, 3'b001, 1'b0, 32'h40, 32'h0, r, e, w);
        checks++; if (e !== SLVERR || r !== (SLVERR ? 32'h0 : s0)) begin
            errors++; $display("FAIL err_range rd=%h err=%b exp %h/%b", r, e, SLVERR ? 32'h0 : s0, SLVERR); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_isolation();
        test_wait_states();
        test_back_to_back();
        test_errors();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_slave_bank.md
# apb_slave_bank

- Parametrised APB completer bank sitting on the APB side of the AHB-to-APB bridge.
- Models NUM_SLAVES peripherals, each a register file of REG_DEPTH words, selected by a one-hot pselx bus.
- Adds true read/write storage, programmable wait states via pready, and error signalling via pslverr.
- Serves as the bridge's integration and verification target in place of a fixed-response stub.

## Interface

Parameters:
- NUM_SLAVES, 3, number of pselx lines and register files (1..8)
- ADDR_WIDTH, 32, paddr width
- DATA_WIDTH, 32, pwdata/prdata width (multiple of 8)
- REG_DEPTH, 16, words per slave (power of 2, ≥2); IDX_W = log2(REG_DEPTH)
- WAIT_STATES, 0, access-phase cycles with pready low before completion (0..15)

Ports:
- hclk  in  1  clock, all state on rising edge
- hresetn  in  1  asynchronous active-low reset
- pselx  in  NUM_SLAVES  one-hot slave select
- penable  in  1  APB access-phase strobe
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_WIDTH  byte address
- pwdata  in  DATA_WIDTH  write data
- prdata  out  DATA_WIDTH  read data, valid when pready=1 on a read
- pready  out  1  transfer completes this cycle
- pslverr  out  1  error response, valid only when pready=1

## Operation

- FSM states: IDLE, ACCESS.
- IDLE → ACCESS on an edge with |pselx=1 and penable=0 (setup phase). At that edge the block latches:
  - slave index: position of the set pselx bit
  - pwrite
  - word index = paddr[2 +: IDX_W]
  - error flag
  - read data = mem[slave][index]
  - wait counter cnt = WAIT_STATES
- Error flag is set when any of the following holds:
  - pselx is not one-hot
  - paddr[1:0] ≠ 0
  - any paddr bit above 2+IDX_W is nonzero
- ACCESS behaviour:
  - pready = (cnt == 0).
  - While cnt ≠ 0, cnt decrements each edge.
  - At the edge where pready=1, penable=1 and |pselx=1, the transfer completes. A write with no error stores pwdata into mem[slave][index]. The FSM then returns to IDLE.
- Back-to-back transfers: after a completion edge the FSM is in IDLE, so the master's next setup cycle is accepted normally. Minimum transfer is 2 cycles.
- Abort: in ACCESS, if pselx=0 or penable=0 at an edge, the FSM returns to IDLE. No write occurs and pready/pslverr never assert for that transfer.
- Errored write: memory is unchanged. Errored read returns prdata=0.
- prdata holds its last value outside read completions. Write completions do not change prdata.
- Reset, asynchronous, including mid-transfer:
  - FSM = IDLE, cnt = 0
  - prdata = 0, pready = 0, pslverr = 0
  - every register word = 0
  - any pending transfer is dropped

## Timing

- WAIT_STATES=0: setup cycle N, access cycle N+1 with pready=1. Write takes effect after edge N+1. Read data is valid in cycle N+1.
- WAIT_STATES=W: pready low for cycles N+1..N+W and high in cycle N+1+W.
- Read data is sampled at the setup edge. A write to the same word completing on that edge is not visible; transfers never overlap, so this cannot occur on a legal bus.
- All outputs are registered or decoded from FSM/cnt registers only. No combinational path from inputs to outputs.

## Configuration

- APB_SLVERR_EN defined:
  - pslverr = error flag while pready=1, else 0
  - error suppresses writes and zeroes read data
- APB_SLVERR_EN undefined:
  - pslverr tied 0
  - error detection logic removed
  - the word index is still taken from paddr[2 +: IDX_W]; upper and misaligned address bits are ignored
  - non-one-hot pselx selects the lowest set bit
  - all transfers complete normally

## Test plan

- Reset state: hresetn low mid-ACCESS, WAIT_STATES=3 → pready=0, pslverr=0, prdata=0 immediately. Afterwards, a read of slave 1 word 5 returns 0.
- Write then read, WAIT_STATES=0: write 0xDEADBEEF to pselx=3'b010, paddr=0x14; then read the same address → each transfer is 2 cycles with pready=1 in the access cycle, and the read returns prdata=0xDEADBEEF.
- Slave isolation: write 0x11111111 to slave 0 word 2 and 0x22222222 to slave 2 word 2 → reads return the respective values. Slave 1 word 2 reads 0.
- Wait states, WAIT_STATES=2: single read → pready low for 2 access cycles and high on the 3rd. Memory is unchanged if penable drops before pready (abort case).
- Errors with APB_SLVERR_EN defined:
  - pselx=3'b011 write 0xAA → pslverr=1, no slave changes
  - paddr=0x42 → pslverr=1, prdata=0
  - paddr=0x40 with REG_DEPTH=16 → pslverr=1
- Errors without APB_SLVERR_EN: the same stimuli → pslverr=0. pselx=3'b011 writes slave 0, and paddr=0x40 aliases word 0.
